// File: rtl/load_down_timer_if.sv
// Bus bundle for load_down_timer: control/data inputs and registered status outputs.
// The master modport drives the controls; the slave modport is the timer side.
interface load_down_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, data_in, start, pause, periodic,
    input  count, tc, busy, done
  );

  modport slave (
    input  load, data_in, start, pause, periodic,
    output count, tc, busy, done
  );
endinterface

// File: rtl/load_down_timer.sv
// Loadable down-counting timer with pause/hold, terminal-count pulse and DONE state.
// Optional feature macro AUTO_RELOAD_EN: periodic reload from reload_reg at terminal count.
module load_down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  load_down_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

`ifndef AUTO_RELOAD_EN
  logic unused_periodic_s;
  assign unused_periodic_s = bus.periodic;
`endif

  // State, count, reload value and terminal pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load beats pause, pause beats start, start beats decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      count_d  = bus.data_in;
      reload_d = bus.data_in;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (count_q != CNT_ZERO) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_HOLD;
          end else if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else if (count_q == CNT_ONE) begin
            tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
            if (bus.periodic) begin
              count_d = reload_q;
              state_d = ST_RUN;
            end else begin
              count_d = CNT_ZERO;
              state_d = ST_DONE;
            end
`else
            count_d = CNT_ZERO;
            state_d = ST_DONE;
`endif
          end else begin
            // A zero count in RUN cannot arise; retire quietly rather than wrap.
            count_d = CNT_ZERO;
            state_d = ST_DONE;
          end
        end

        ST_HOLD: begin
          if (bus.pause) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          if (bus.start) begin
            count_d = reload_q;
            if (reload_q != CNT_ZERO) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end
          end else begin
            count_d = CNT_ZERO;
            state_d = ST_DONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_load_down_timer.sv
// Self-checking bench for load_down_timer: directed literal sequences plus random
// stimulus compared every cycle against a behavioural reference model.
module tb_load_down_timer;
  localparam int W = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  load_down_timer_if #(.WIDTH(W)) bus ();

  load_down_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  int m_mode   = M_IDLE;
  int m_count  = 0;
  int m_reload = 0;
  bit m_tc     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference rules applied to one clock edge.
  function automatic void model_next(input logic r, input logic ld, input int din,
                                     input logic st, input logic ps, input logic per,
                                     input int mode, input int cnt, input int rel,
                                     output int n_mode, output int n_cnt,
                                     output int n_rel, output bit n_tc);
    n_mode = mode; n_cnt = cnt; n_rel = rel; n_tc = 1'b0;
    if (r) begin
      n_mode = M_IDLE; n_cnt = 0; n_rel = 0;
    end else if (ld) begin
      n_mode = M_IDLE; n_cnt = din; n_rel = din;
    end else if (mode == M_RUN) begin
      if (ps) n_mode = M_HOLD;
      else if (cnt > 1) n_cnt = cnt - 1;
      else begin
        n_tc = 1'b1;
`ifdef AUTO_RELOAD_EN
        if (per) n_cnt = rel;
        else begin n_cnt = 0; n_mode = M_DONE; end
`else
        n_cnt = 0; n_mode = M_DONE;
`endif
      end
    end else if (mode == M_HOLD) begin
      if (!ps) n_mode = M_RUN;
    end else if (st) begin
      if (mode == M_DONE) n_cnt = rel;
      if (n_cnt != 0) n_mode = M_RUN;
      else begin n_mode = M_DONE; n_tc = 1'b1; end
    end
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin
    int nm, nc, nr;
    bit nt;
    model_next(rst, bus.load, int'(bus.data_in), bus.start, bus.pause, bus.periodic,
               m_mode, m_count, m_reload, nm, nc, nr, nt);
    m_mode   <= nm;
    m_count  <= nc;
    m_reload <= nr;
    m_tc     <= nt;
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_count", 32'(bus.count), 32'(m_count));
      check("model_tc",    32'(bus.tc),    32'(m_tc));
      check("model_busy",  32'(bus.busy),  32'((m_mode == M_RUN) || (m_mode == M_HOLD)));
      check("model_done",  32'(bus.done),  32'(m_mode == M_DONE));
    end
  end

  task automatic step(input logic r, input logic ld, input int din,
                      input logic st, input logic ps, input logic per);
    rst          = r;
    bus.load     = ld;
    bus.data_in  = W'(din);
    bus.start    = st;
    bus.pause    = ps;
    bus.periodic = per;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int c, input bit t, input bit b, input bit d);
    check({name, "_count"}, 32'(bus.count), 32'(c));
    check({name, "_tc"},    32'(bus.tc),    32'(t));
    check({name, "_busy"},  32'(bus.busy),  32'(b));
    check({name, "_done"},  32'(bus.done),  32'(d));
  endtask

  initial begin
    logic per_r;
    step(1, 0, 0, 0, 0, 0);  lit("reset", 0, 0, 0, 0);
    check_en = 1'b1;

    // load 3, start: 3,2,1,0 with single tc, then DONE; restart from DONE reloads 3
    step(0, 1, 3, 0, 0, 0);  lit("l3_load", 3, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);  lit("l3_s", 3, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);  lit("l3_c2_hold", 3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l3_resume", 3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l3_c2", 2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l3_c1", 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l3_c0", 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0);  lit("l3_done", 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);  lit("l3_restart", 3, 0, 1, 0);

    // load 5, pause at 3 for 3 edges, release
    step(0, 1, 5, 0, 0, 0);  lit("l5_load", 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);  lit("l5_s", 5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l5_c4", 4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l5_c3", 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 0);  lit("l5_hold", 3, 0, 1, 0);
    end
    step(0, 0, 0, 0, 0, 0);  lit("l5_rel", 3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l5_c2", 2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l5_c1", 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l5_c0", 0, 1, 0, 1);

    // pause wins at count 1
    step(0, 1, 2, 0, 0, 0);  step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);  lit("p1_c1", 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);  lit("p1_hold", 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("p1_rel", 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);  lit("p1_tc", 0, 1, 0, 1);

    // load 0: immediate DONE pulse, repeat start in DONE gives another single pulse
    step(0, 1, 0, 0, 0, 0);  lit("l0_load", 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);  lit("l0_s", 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);  lit("l0_idle", 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);  lit("l0_s2", 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);  lit("l0_s2_end", 0, 0, 0, 1);

    // load abort mid-run, then rst abort mid-run
    step(0, 1, 4, 0, 0, 0);  step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);  step(0, 0, 0, 0, 0, 0);  lit("l4_c2", 2, 0, 1, 0);
    step(0, 1, 7, 0, 0, 0);  lit("l7_abort", 7, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);  step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);  lit("l7_c5", 5, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);  lit("rst_abort", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);  lit("rst_quiet", 0, 0, 0, 0);

    // same-edge priority
    step(0, 1, 9, 1, 0, 0);  lit("load_vs_start", 9, 0, 0, 0);
    step(1, 1, 6, 1, 0, 0);  lit("rst_vs_load", 0, 0, 0, 0);

    // periodic request: reload in RUN only when the feature is built
    step(0, 1, 3, 0, 0, 1);  step(0, 0, 0, 1, 0, 1);  lit("per_s", 3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);  step(0, 0, 0, 0, 0, 1);  lit("per_c1", 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
`ifdef AUTO_RELOAD_EN
    lit("per_rl1", 3, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);  step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);  lit("per_rl2", 3, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);  step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);  lit("per_drop", 0, 1, 0, 1);
`else
    lit("per_ignored", 0, 1, 0, 1);
`endif

    // randomized traffic checked by the model
    per_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) per_r = ~per_r;
      step(($urandom_range(80) == 0), ($urandom_range(14) == 0), int'($urandom_range(15)),
           ($urandom_range(5) == 0), ($urandom_range(4) == 0), per_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
